// File: rtl/rvfi_commit_tracker_pkg.sv
// Shared types for the RVFI commit tracker: RV32I base opcodes and the
// per-ROB-entry shadow record that doubles as the outgoing RVFI packet.
package rvfi_commit_tracker_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef struct packed {
        logic        valid;
        logic        wb_done;
        logic        mem_done;
        logic [31:0] inst;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_word_t;

endpackage

// File: rtl/rvfi_commit_tracker_field_decode.sv
// Extracts register addresses from an instruction word, zeroing the fields
// that the instruction format does not actually use as registers.
module rvfi_field_decode
    import rvfi_commit_tracker_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr
);

    always_comb begin
        o_rs1_addr = i_inst[19:15];
        o_rs2_addr = i_inst[24:20];
        o_rd_addr  = i_inst[11:7];
        case (i_inst[6:0])
            op_store, op_br: o_rd_addr = 5'd0;
            op_lui, op_auipc, op_jal: begin
                o_rs1_addr = 5'd0;
                o_rs2_addr = 5'd0;
            end
            op_imm, op_load, op_jalr: o_rs2_addr = 5'd0;
            default: ;
        endcase
    end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Shadow store indexed by ROB tag; collects side effects per instruction and
// emits one registered RVFI packet per ROB commit, in program order.
module rvfi_commit_tracker
    import rvfi_commit_tracker_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_disp_valid,
    input  logic [TAG_W-1:0] i_disp_tag,
    input  logic [31:0]      i_disp_pc,
    input  logic [31:0]      i_disp_inst,
    input  logic             i_opnd_valid,
    input  logic [TAG_W-1:0] i_opnd_tag,
    input  logic [31:0]      i_opnd_rs1_data,
    input  logic [31:0]      i_opnd_rs2_data,
    input  logic             i_wb_valid,
    input  logic [TAG_W-1:0] i_wb_tag,
    input  logic [31:0]      i_wb_rd_data,
    input  logic [31:0]      i_wb_pc_next,
    input  logic             i_mem_valid,
    input  logic [TAG_W-1:0] i_mem_tag,
    input  logic [31:0]      i_mem_addr,
    input  logic [3:0]       i_mem_rmask,
    input  logic [3:0]       i_mem_wmask,
    input  logic [31:0]      i_mem_rdata,
    input  logic [31:0]      i_mem_wdata,
    input  logic             i_commit_valid,
    input  logic [TAG_W-1:0] i_commit_tag,
    input  logic             i_flush,
    output logic             o_rvfi_valid,
    output logic [63:0]      o_rvfi_order,
    output logic [31:0]      o_rvfi_inst,
    output logic [31:0]      o_rvfi_pc_rdata,
    output logic [31:0]      o_rvfi_pc_wdata,
    output logic [4:0]       o_rvfi_rs1_addr,
    output logic [4:0]       o_rvfi_rs2_addr,
    output logic [4:0]       o_rvfi_rd_addr,
    output logic [31:0]      o_rvfi_rs1_rdata,
    output logic [31:0]      o_rvfi_rs2_rdata,
    output logic [31:0]      o_rvfi_rd_wdata,
    output logic [31:0]      o_rvfi_mem_addr,
    output logic [3:0]       o_rvfi_mem_rmask,
    output logic [3:0]       o_rvfi_mem_wmask,
    output logic [31:0]      o_rvfi_mem_rdata,
    output logic [31:0]      o_rvfi_mem_wdata,
    output logic             o_rvfi_halt,
    output logic             o_err_incomplete
);

    rvfi_word_t  r_rob [ROB_DEPTH];
    rvfi_word_t  r_pkt;
    logic [63:0] r_order_cnt;
    logic [63:0] r_pkt_order;
    logic        r_halt;
    logic        r_err;

    rvfi_word_t  w_new;
    rvfi_word_t  w_pkt;
    logic [4:0]  w_rs1_addr;
    logic [4:0]  w_rs2_addr;
    logic [4:0]  w_rd_addr;
    logic        w_unused_ok;

    rvfi_field_decode u_decode (
        .i_inst     (i_disp_inst),
        .o_rs1_addr (w_rs1_addr),
        .o_rs2_addr (w_rs2_addr),
        .o_rd_addr  (w_rd_addr)
    );

    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.inst     = i_disp_inst;
        w_new.pc_rdata = i_disp_pc;
        w_new.pc_wdata = i_disp_pc + 32'd4;
        w_new.rs1_addr = w_rs1_addr;
        w_new.rs2_addr = w_rs2_addr;
        w_new.rd_addr  = w_rd_addr;
    end

    // Packet is taken from the entry as it stands before this edge's updates.
    always_comb begin
        w_pkt       = r_rob[i_commit_tag];
        w_pkt.valid = 1'b1;
        if (w_pkt.rd_addr == 5'd0) w_pkt.rd_wdata = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) r_rob[i] <= '0;
            r_pkt       <= '0;
            r_pkt_order <= '0;
            r_order_cnt <= '0;
            r_halt      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pkt.valid <= 1'b0;
            if (i_commit_valid) begin
                r_pkt       <= w_pkt;
                r_pkt_order <= r_order_cnt;
                r_order_cnt <= r_order_cnt + 64'd1;
                if (w_pkt.pc_rdata == w_pkt.pc_wdata) r_halt <= 1'b1;
                if (!r_rob[i_commit_tag].valid || !r_rob[i_commit_tag].wb_done)
                    r_err <= 1'b1;
            end

            if (i_flush) begin
                for (int i = 0; i < ROB_DEPTH; i++) r_rob[i].valid <= 1'b0;
            end else begin
                if (i_opnd_valid && r_rob[i_opnd_tag].valid) begin
                    r_rob[i_opnd_tag].rs1_rdata <=
                        (r_rob[i_opnd_tag].rs1_addr == 5'd0) ? 32'd0 : i_opnd_rs1_data;
                    r_rob[i_opnd_tag].rs2_rdata <=
                        (r_rob[i_opnd_tag].rs2_addr == 5'd0) ? 32'd0 : i_opnd_rs2_data;
                end
                if (i_wb_valid && r_rob[i_wb_tag].valid) begin
                    r_rob[i_wb_tag].rd_wdata <= i_wb_rd_data;
                    r_rob[i_wb_tag].pc_wdata <= i_wb_pc_next;
                    r_rob[i_wb_tag].wb_done  <= 1'b1;
                end
                if (i_mem_valid && r_rob[i_mem_tag].valid) begin
                    r_rob[i_mem_tag].mem_addr  <= i_mem_addr;
                    r_rob[i_mem_tag].mem_rmask <= i_mem_rmask;
                    r_rob[i_mem_tag].mem_wmask <= i_mem_wmask;
                    r_rob[i_mem_tag].mem_rdata <= i_mem_rdata;
                    r_rob[i_mem_tag].mem_wdata <= i_mem_wdata;
                    r_rob[i_mem_tag].mem_done  <= 1'b1;
                end
                if (i_commit_valid) r_rob[i_commit_tag].valid <= 1'b0;
                // A dispatch reusing the committing tag overrides the clear above.
                if (i_disp_valid) r_rob[i_disp_tag] <= w_new;
            end
        end
    end

    assign w_unused_ok = r_pkt.wb_done ^ r_pkt.mem_done;

    assign o_rvfi_valid     = r_pkt.valid;
    assign o_rvfi_order     = r_pkt_order;
    assign o_rvfi_inst      = r_pkt.inst;
    assign o_rvfi_pc_rdata  = r_pkt.pc_rdata;
    assign o_rvfi_pc_wdata  = r_pkt.pc_wdata;
    assign o_rvfi_rs1_addr  = r_pkt.rs1_addr;
    assign o_rvfi_rs2_addr  = r_pkt.rs2_addr;
    assign o_rvfi_rd_addr   = r_pkt.rd_addr;
    assign o_rvfi_rs1_rdata = r_pkt.rs1_rdata;
    assign o_rvfi_rs2_rdata = r_pkt.rs2_rdata;
    assign o_rvfi_rd_wdata  = r_pkt.rd_wdata;
    assign o_rvfi_mem_addr  = r_pkt.mem_addr;
    assign o_rvfi_mem_rmask = r_pkt.mem_rmask;
    assign o_rvfi_mem_wmask = r_pkt.mem_wmask;
    assign o_rvfi_mem_rdata = r_pkt.mem_rdata;
    assign o_rvfi_mem_wdata = r_pkt.mem_wdata;
    assign o_rvfi_halt      = r_halt;
    assign o_err_incomplete = r_err;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Bench for rvfi_commit_tracker: decode vector table, directed multi-cycle
// sequences and a randomized run, all checked against a per-tag reference model.
module tb_rvfi_commit_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_valid = 0, opnd_valid = 0, wb_valid = 0, mem_valid = 0;
    logic        commit_valid = 0, flush = 0;
    logic [2:0]  disp_tag = 0, opnd_tag = 0, wb_tag = 0, mem_tag = 0, commit_tag = 0;
    logic [31:0] disp_pc = 0, disp_inst = 0, opnd_rs1 = 0, opnd_rs2 = 0;
    logic [31:0] wb_rd = 0, wb_pcn = 0, mem_addr = 0, mem_rdata = 0, mem_wdata = 0;
    logic [3:0]  mem_rmask = 0, mem_wmask = 0;

    logic        o_valid, o_halt, o_err;
    logic [63:0] o_order;
    logic [31:0] o_inst, o_pc_r, o_pc_w, o_rs1_d, o_rs2_d, o_rd_d;
    logic [4:0]  o_rs1_a, o_rs2_a, o_rd_a;
    logic [31:0] o_m_addr, o_m_rdata, o_m_wdata;
    logic [3:0]  o_m_rmask, o_m_wmask;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rvfi_commit_tracker dut (
        .i_clk(clk), .i_rst(rst),
        .i_disp_valid(disp_valid), .i_disp_tag(disp_tag), .i_disp_pc(disp_pc), .i_disp_inst(disp_inst),
        .i_opnd_valid(opnd_valid), .i_opnd_tag(opnd_tag),
        .i_opnd_rs1_data(opnd_rs1), .i_opnd_rs2_data(opnd_rs2),
        .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_rd_data(wb_rd), .i_wb_pc_next(wb_pcn),
        .i_mem_valid(mem_valid), .i_mem_tag(mem_tag), .i_mem_addr(mem_addr),
        .i_mem_rmask(mem_rmask), .i_mem_wmask(mem_wmask),
        .i_mem_rdata(mem_rdata), .i_mem_wdata(mem_wdata),
        .i_commit_valid(commit_valid), .i_commit_tag(commit_tag), .i_flush(flush),
        .o_rvfi_valid(o_valid), .o_rvfi_order(o_order), .o_rvfi_inst(o_inst),
        .o_rvfi_pc_rdata(o_pc_r), .o_rvfi_pc_wdata(o_pc_w),
        .o_rvfi_rs1_addr(o_rs1_a), .o_rvfi_rs2_addr(o_rs2_a), .o_rvfi_rd_addr(o_rd_a),
        .o_rvfi_rs1_rdata(o_rs1_d), .o_rvfi_rs2_rdata(o_rs2_d), .o_rvfi_rd_wdata(o_rd_d),
        .o_rvfi_mem_addr(o_m_addr), .o_rvfi_mem_rmask(o_m_rmask), .o_rvfi_mem_wmask(o_m_wmask),
        .o_rvfi_mem_rdata(o_m_rdata), .o_rvfi_mem_wdata(o_m_wdata),
        .o_rvfi_halt(o_halt), .o_err_incomplete(o_err)
    );

    // Reference model: one record per tag, updated by the architectural rules.
    logic        m_v [8], m_wb [8];
    logic [31:0] m_inst [8], m_pc [8], m_pcw [8], m_r1d [8], m_r2d [8], m_rdd [8];
    logic [31:0] m_ma [8], m_mrd [8], m_mwd [8];
    logic [3:0]  m_rm [8], m_wm [8];
    logic [4:0]  m_r1a [8], m_r2a [8], m_rda [8];
    logic [63:0] m_cnt;

    logic        e_valid, e_halt, e_err;
    logic [63:0] e_order;
    logic [31:0] e_inst, e_pc, e_pcw, e_r1d, e_r2d, e_rdd, e_ma, e_mrd, e_mwd;
    logic [3:0]  e_rm, e_wm;
    logic [4:0]  e_r1a, e_r2a, e_rda;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void reg_fields(input logic [31:0] inst,
                                       output logic [4:0] a1, output logic [4:0] a2,
                                       output logic [4:0] ad);
        a1 = inst[19:15];
        a2 = inst[24:20];
        ad = inst[11:7];
        if (inst[6:0] == 7'h23 || inst[6:0] == 7'h63) ad = 0;
        if (inst[6:0] == 7'h37 || inst[6:0] == 7'h17 || inst[6:0] == 7'h6f) begin
            a1 = 0;
            a2 = 0;
        end
        if (inst[6:0] == 7'h13 || inst[6:0] == 7'h03 || inst[6:0] == 7'h67) a2 = 0;
    endfunction

    task automatic model_step();
        int  t;
        logic v0 [8];
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_v[i] = 0; m_wb[i] = 0; m_inst[i] = 0; m_pc[i] = 0; m_pcw[i] = 0;
                m_r1d[i] = 0; m_r2d[i] = 0; m_rdd[i] = 0; m_ma[i] = 0; m_mrd[i] = 0;
                m_mwd[i] = 0; m_rm[i] = 0; m_wm[i] = 0; m_r1a[i] = 0; m_r2a[i] = 0; m_rda[i] = 0;
            end
            m_cnt = 0; e_valid = 0; e_halt = 0; e_err = 0;
            return;
        end
        e_valid = commit_valid;
        if (commit_valid) begin
            t = int'(commit_tag);
            e_inst = m_inst[t]; e_pc = m_pc[t]; e_pcw = m_pcw[t];
            e_r1a = m_r1a[t]; e_r2a = m_r2a[t]; e_rda = m_rda[t];
            e_r1d = m_r1d[t]; e_r2d = m_r2d[t];
            e_rdd = (m_rda[t] == 0) ? 32'd0 : m_rdd[t];
            e_ma = m_ma[t]; e_rm = m_rm[t]; e_wm = m_wm[t]; e_mrd = m_mrd[t]; e_mwd = m_mwd[t];
            e_order = m_cnt;
            m_cnt++;
            if (m_pc[t] == m_pcw[t]) e_halt = 1;
            if (!m_v[t] || !m_wb[t]) e_err = 1;
        end
        if (flush) begin
            for (int i = 0; i < 8; i++) m_v[i] = 0;
            return;
        end
        for (int i = 0; i < 8; i++) v0[i] = m_v[i];
        if (opnd_valid && v0[opnd_tag]) begin
            m_r1d[opnd_tag] = (m_r1a[opnd_tag] == 0) ? 32'd0 : opnd_rs1;
            m_r2d[opnd_tag] = (m_r2a[opnd_tag] == 0) ? 32'd0 : opnd_rs2;
        end
        if (wb_valid && v0[wb_tag]) begin
            m_rdd[wb_tag] = wb_rd; m_pcw[wb_tag] = wb_pcn; m_wb[wb_tag] = 1;
        end
        if (mem_valid && v0[mem_tag]) begin
            m_ma[mem_tag] = mem_addr; m_rm[mem_tag] = mem_rmask; m_wm[mem_tag] = mem_wmask;
            m_mrd[mem_tag] = mem_rdata; m_mwd[mem_tag] = mem_wdata;
        end
        if (commit_valid) m_v[commit_tag] = 0;
        if (disp_valid) begin
            t = int'(disp_tag);
            m_v[t] = 1; m_wb[t] = 0; m_inst[t] = disp_inst; m_pc[t] = disp_pc;
            m_pcw[t] = disp_pc + 32'd4;
            m_r1d[t] = 0; m_r2d[t] = 0; m_rdd[t] = 0;
            m_ma[t] = 0; m_rm[t] = 0; m_wm[t] = 0; m_mrd[t] = 0; m_mwd[t] = 0;
            reg_fields(disp_inst, m_r1a[t], m_r2a[t], m_rda[t]);
        end
    endtask

    // One clock: advance model, take the edge, compare, return inputs to idle.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("valid", o_valid, e_valid);
        chk("halt", o_halt, e_halt);
        chk("err_incomplete", o_err, e_err);
        if (e_valid) begin
            chk("order", o_order, e_order);
            chk("inst", o_inst, e_inst);
            chk("pc_rdata", o_pc_r, e_pc);
            chk("pc_wdata", o_pc_w, e_pcw);
            chk("reg_addrs", {o_rs1_a, o_rs2_a, o_rd_a}, {e_r1a, e_r2a, e_rda});
            chk("rs1_rdata", o_rs1_d, e_r1d);
            chk("rs2_rdata", o_rs2_d, e_r2d);
            chk("rd_wdata", o_rd_d, e_rdd);
            chk("mem_addr", o_m_addr, e_ma);
            chk("mem_masks", {o_m_rmask, o_m_wmask}, {e_rm, e_wm});
            chk("mem_rdata", o_m_rdata, e_mrd);
            chk("mem_wdata", o_m_wdata, e_mwd);
        end
        disp_valid = 0; opnd_valid = 0; wb_valid = 0; mem_valid = 0;
        commit_valid = 0; flush = 0; rst = 0;
    endtask

    task automatic disp(input int t, input logic [31:0] pc, input logic [31:0] inst);
        disp_valid = 1; disp_tag = 3'(t); disp_pc = pc; disp_inst = inst;
    endtask
    task automatic opnd(input int t, input logic [31:0] a, input logic [31:0] b);
        opnd_valid = 1; opnd_tag = 3'(t); opnd_rs1 = a; opnd_rs2 = b;
    endtask
    task automatic wb(input int t, input logic [31:0] d, input logic [31:0] n);
        wb_valid = 1; wb_tag = 3'(t); wb_rd = d; wb_pcn = n;
    endtask
    task automatic com(input int t);
        commit_valid = 1; commit_tag = 3'(t);
    endtask
    task automatic do_reset();
        rst = 1;
        cycle();
    endtask

    typedef struct {
        logic [31:0] pc, inst, r1, r2, rd, pcn;
        logic [4:0]  xa1, xa2, xad;
        logic [31:0] xr1, xr2, xrd;
    } vec_t;
    vec_t tbl [8];

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    initial begin
        logic [31:0] rnd;
        logic [6:0]  ops [10];

        tbl[0] = '{32'h60,  32'h00700293, 32'h0, R2, 32'h7,         32'h64,  5'd0,  5'd0, 5'd5,  32'h0, 32'h0, 32'h7};
        tbl[1] = '{32'h64,  32'h002081b3, R1,    R2, 32'h3333_3333, 32'h68,  5'd1,  5'd2, 5'd3,  R1,    R2,    32'h3333_3333};
        tbl[2] = '{32'h68,  32'h123453b7, R1,    R2, 32'h1234_5000, 32'h6c,  5'd0,  5'd0, 5'd7,  32'h0, 32'h0, 32'h1234_5000};
        tbl[3] = '{32'h6c,  32'h00208463, R1,    R2, 32'h3333_3333, 32'h74,  5'd1,  5'd2, 5'd0,  R1,    R2,    32'h0};
        tbl[4] = '{32'h74,  32'h0045a503, R1,    R2, 32'h4444_4444, 32'h78,  5'd11, 5'd0, 5'd10, R1,    32'h0, 32'h4444_4444};
        tbl[5] = '{32'h78,  32'h010280e7, R1,    R2, 32'h7c,        32'h200, 5'd5,  5'd0, 5'd1,  R1,    32'h0, 32'h7c};
        tbl[6] = '{32'h200, 32'hfffff217, R1,    R2, 32'hffff_f200, 32'h204, 5'd0,  5'd0, 5'd4,  32'h0, 32'h0, 32'hffff_f200};
        tbl[7] = '{32'h204, 32'h0062a223, R1,    R2, 32'h5555_5555, 32'h208, 5'd5,  5'd6, 5'd0,  R1,    R2,    32'h0};

        // Reset state
        do_reset();
        chk("rst_valid", o_valid, 0);
        chk("rst_order", o_order, 0);
        chk("rst_halt", o_halt, 0);
        chk("rst_err", o_err, 0);
        chk("rst_fields", {o_inst, o_pc_r, o_pc_w, o_rd_d, o_m_wdata}, 0);

        // Decode/mask vectors; row 0 is the addi x5,x0,7 at tag 2
        for (int i = 0; i < 8; i++) begin
            int t;
            t = (i + 2) % 8;
            disp(t, tbl[i].pc, tbl[i].inst);
            cycle();
            opnd(t, tbl[i].r1, tbl[i].r2);
            wb(t, tbl[i].rd, tbl[i].pcn);
            cycle();
            com(t);
            cycle();
            chk("vec_valid", o_valid, 1);
            chk("vec_order", o_order, 64'(i));
            chk("vec_inst", o_inst, tbl[i].inst);
            chk("vec_pc", {o_pc_r, o_pc_w}, {tbl[i].pc, tbl[i].pcn});
            chk("vec_addrs", {o_rs1_a, o_rs2_a, o_rd_a}, {tbl[i].xa1, tbl[i].xa2, tbl[i].xad});
            chk("vec_rs_data", {o_rs1_d, o_rs2_d}, {tbl[i].xr1, tbl[i].xr2});
            chk("vec_rd_wdata", o_rd_d, tbl[i].xrd);
            chk("vec_err", o_err, 0);
        end

        // Store with opnd, wb and mem all landing in one cycle
        disp(3, 32'h100, 32'h0062a223);
        cycle();
        opnd(3, 32'h100, 32'hDEADBEEF);
        wb(3, 32'h9999_9999, 32'h104);
        mem_valid = 1; mem_tag = 3; mem_addr = 32'h104; mem_rmask = 0; mem_wmask = 4'hF;
        mem_rdata = 0; mem_wdata = 32'hDEADBEEF;
        cycle();
        com(3);
        cycle();
        chk("st_rd", {27'd0, o_rd_a, o_rd_d}, 0);
        chk("st_mem_addr", o_m_addr, 32'h104);
        chk("st_masks", {o_m_rmask, o_m_wmask}, 8'h0F);
        chk("st_wdata", o_m_wdata, 32'hDEADBEEF);

        // Fill all tags, retire in order, then reuse tag 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            disp(i, 32'h1000 + 32'(4 * i), 32'h002081b3);
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            wb(i, 32'h100 + 32'(i), 32'h1004 + 32'(4 * i));
            cycle();
        end
        for (int i = 0; i < 8; i++) begin
            com(i);
            cycle();
            chk("fill_order", o_order, 64'(i));
            chk("fill_pc", o_pc_r, 32'h1000 + 32'(4 * i));
        end
        disp(0, 32'h2000, 32'h00000013);
        cycle();
        wb(0, 32'h0, 32'h2004);
        cycle();
        com(0);
        disp(0, 32'h3000, 32'h00100093);
        cycle();
        chk("reuse_order", o_order, 64'd8);
        chk("reuse_pc", o_pc_r, 32'h2000);
        wb(0, 32'h1, 32'h3004);
        cycle();
        com(0);
        cycle();
        chk("reuse2_order", o_order, 64'd9);
        chk("reuse2_pc_rd", {o_pc_r, o_rd_d}, {32'h3000, 32'h1});
        chk("reuse2_err", o_err, 0);

        // Flush racing a commit, then late wb to a squashed entry
        do_reset();
        disp(4, 32'h400, 32'h002081b3);
        cycle();
        disp(5, 32'h404, 32'h002081b3);
        wb(4, 32'hAA, 32'h404);
        cycle();
        com(4);
        flush = 1;
        disp(6, 32'h500, 32'h002081b3);
        cycle();
        chk("flush_pkt", {31'd0, o_valid, o_pc_r, o_rd_d}, {32'd1, 32'h400, 32'hAA});
        chk("flush_err0", o_err, 0);
        wb(5, 32'hBB, 32'h408);
        cycle();
        chk("flush_idle", o_valid, 0);
        com(5);
        cycle();
        chk("flush_err1", {o_valid, o_err}, 2'b11);
        chk("flush_wb_ignored", {o_pc_r, o_pc_w, o_rd_d}, {32'h404, 32'h408, 32'h0});

        // Self-loop jal raises sticky halt
        do_reset();
        disp(1, 32'h80, 32'h0000006f);
        cycle();
        wb(1, 32'h84, 32'h80);
        cycle();
        chk("halt_pre", o_halt, 0);
        com(1);
        cycle();
        chk("halt_pkt", {o_valid, o_halt}, 2'b11);
        chk("halt_pc", {o_pc_r, o_pc_w}, {32'h80, 32'h80});
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("halt_sticky", o_halt, 1);
        end
        do_reset();
        chk("halt_cleared", o_halt, 0);

        // Reset right after a commit, and reset coinciding with a commit
        disp(1, 32'h300, 32'h00100093);
        cycle();
        com(1);
        cycle();
        chk("pre_rst", {o_valid, o_err}, 2'b11);
        rst = 1;
        cycle();
        chk("post_rst", {o_valid, o_err, o_halt}, 0);
        chk("post_rst_order", o_order, 0);
        disp(2, 32'h310, 32'h00100093);
        wb(2, 32'h1, 32'h314);
        cycle();
        com(2);
        rst = 1;
        cycle();
        chk("rst_commit_dropped", o_valid, 0);
        disp(3, 32'h320, 32'h00100093);
        cycle();
        wb(3, 32'h1, 32'h324);
        cycle();
        com(3);
        cycle();
        chk("rst_restart_order", {o_valid, o_order}, {1'b1, 64'd0});

        // Randomized traffic against the model
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) rst = 1;
            if ($urandom_range(0, 29) == 0) flush = 1;
            if ($urandom_range(0, 1) == 0) begin
                rnd = $urandom();
                disp(int'($urandom_range(0, 7)), $urandom() & 32'hFFFF_FFFC,
                     {rnd[31:7], ops[$urandom_range(0, 9)]});
            end
            if ($urandom_range(0, 4) < 2) opnd(int'($urandom_range(0, 7)), $urandom(), $urandom());
            if ($urandom_range(0, 4) < 2) begin
                wb_valid = 1;
                wb_tag = 3'($urandom_range(0, 7));
                wb_rd = $urandom();
                wb_pcn = ($urandom_range(0, 40) == 0) ? m_pc[wb_tag] : $urandom();
            end
            if ($urandom_range(0, 4) < 2) begin
                mem_valid = 1; mem_tag = 3'($urandom_range(0, 7));
                mem_addr = $urandom(); mem_rdata = $urandom(); mem_wdata = $urandom();
                mem_rmask = 4'($urandom()); mem_wmask = 4'($urandom());
            end
            if ($urandom_range(0, 4) < 2) com(int'($urandom_range(0, 7)));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
